// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// =============================================================================
// fetch_sequencer_if -- instruction-memory request/acknowledge bus.  Rev 1.0
// =============================================================================
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// =============================================================================
// fetch_sequencer -- IF stage with stall buffer, redirect squash and optional
// bubble counter (macro FETCH_PERF_CNT_EN).  Rev 1.0
// =============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     redir_valid_i,
  input  logic [31:0]              redir_pc_i,
  fetch_sequencer_if.master        imem,
  output logic                     if_valid_o,
  output logic [31:0]              if_pc_o,
  output logic [31:0]              if_inst_o,
  output logic [31:0]              bubble_cnt_o
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUF      = 2'd1,
    WAIT_RES = 2'd2,
    SQUASH   = 2'd3
  } state_t;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] sq_addr_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_inst_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic        pending_q;
  logic        if_valid_q;

  logic        w_req;
  logic        w_take;
  logic [31:0] w_pc_inc;

  assign w_req    = ((state_q == FETCH) && (!stall_i || pending_q)) || (state_q == SQUASH);
  assign w_take   = w_req && imem.imem_ack;
  assign w_pc_inc = pc_q + 32'd4;

  // pc_q already holds the redirect target while squashing, so the abandoned
  // request keeps its original address from sq_addr_q until it is acked.
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = (state_q == SQUASH) ? sq_addr_q : pc_q;

  assign if_valid_o = if_valid_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      sq_addr_q  <= 32'h0;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= C_NOP;
      pending_q  <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= C_NOP;
    end else begin
      pending_q <= w_req && !imem.imem_ack;
      if (redir_valid_i) begin
        pc_q       <= redir_pc_i;
        if_valid_q <= 1'b0;
        if (state_q != SQUASH) begin
          sq_addr_q <= pc_q;
        end
        state_q <= (w_req && !imem.imem_ack) ? SQUASH : FETCH;
      end else begin
        // Bubble by default; a delivery below overrides it.
        if (!stall_i) begin
          if_valid_q <= 1'b0;
        end
        case (state_q)
          FETCH: begin
            if (w_take) begin
              if (stall_i) begin
                buf_pc_q   <= pc_q;
                buf_inst_q <= imem.imem_rdata;
                state_q    <= BUF;
              end else begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_inst_q  <= imem.imem_rdata;
                pc_q       <= w_pc_inc;
                state_q    <= imem.imem_rdata[6] ? WAIT_RES : FETCH;
              end
            end
          end
          BUF: begin
            if (!stall_i) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= buf_pc_q;
              if_inst_q  <= buf_inst_q;
              pc_q       <= w_pc_inc;
              state_q    <= buf_inst_q[6] ? WAIT_RES : FETCH;
            end
          end
          WAIT_RES: begin
            state_q <= WAIT_RES;
          end
          SQUASH: begin
            if (imem.imem_ack) begin
              state_q <= FETCH;
            end
          end
          default: begin
            state_q <= FETCH;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt_q <= 32'h0;
    end else if (!if_valid_q && !stall_i) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign bubble_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// =============================================================================
// tb_fetch_sequencer -- directed self-checking bench for fetch_sequencer.  Rev 1.0
// =============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redir_valid_i = 1'b0;
  logic [31:0] redir_pc_i = 32'h0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic [31:0] bubble_cnt_o;

  int          lat = 0;
  int          wait_cnt = 0;
  logic [31:0] br_addr = 32'h0000_0010;
  int          n_checks = 0;
  int          n_errors = 0;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redir_valid_i(redir_valid_i),
    .redir_pc_i   (redir_pc_i),
    .imem         (imem_bus),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction image: upper bits = word index + 1, opcode 0x63 (bit6=1) at br_addr.
  function automatic logic [31:0] inst_at(input logic [31:0] a, input logic [31:0] br);
    logic [24:0] w;
    w = a[26:2] + 25'd1;
    return {w, (a == br) ? 7'h63 : 7'h13};
  endfunction

  assign imem_bus.imem_ack   = rst_n && imem_bus.imem_req && (wait_cnt >= lat);
  assign imem_bus.imem_rdata = inst_at(imem_bus.imem_addr, br_addr);

  always @(posedge clk) begin
    if (!rst_n || !imem_bus.imem_req || imem_bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_in [4] = '{32'h93, 32'h113, 32'h193, 32'h213};

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
    chk("rst_pc", if_pc_o, 32'h0);
    chk("rst_inst", if_inst_o, 32'h13);
    chk("rst_bubble", bubble_cnt_o, 32'h0);
    chk("rst_addr", imem_bus.imem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'h0, imem_bus.imem_req}, 32'h1);

    // Straight-line zero-wait stream
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("str_valid", {31'h0, if_valid_o}, 32'h1);
      chk("str_pc", if_pc_o, exp_pc[i]);
      chk("str_inst", if_inst_o, exp_in[i]);
`ifdef FETCH_PERF_CNT_EN
      if (i == 0) chk("bub_1", bubble_cnt_o, 32'd1);
`endif
    end

    // Branch at 0x10 -> wait for resolution, redirect to 0x40
    tick();
    chk("br_pc", if_pc_o, 32'h10);
    chk("br_inst", if_inst_o, 32'h2E3);
    chk("br_req_low", {31'h0, imem_bus.imem_req}, 32'h0);
    tick();
    chk("br_bubble", {31'h0, if_valid_o}, 32'h0);
    chk("br_req_low2", {31'h0, imem_bus.imem_req}, 32'h0);
    redir_valid_i = 1'b1;
    redir_pc_i    = 32'h40;
    tick();
    redir_valid_i = 1'b0;
    chk("rd_valid", {31'h0, if_valid_o}, 32'h0);
    chk("rd_addr", imem_bus.imem_addr, 32'h40);
    chk("rd_req", {31'h0, imem_bus.imem_req}, 32'h1);
    tick();
    chk("rd_pc", if_pc_o, 32'h40);
    chk("rd_inst", if_inst_o, 32'h893);
`ifdef FETCH_PERF_CNT_EN
    chk("bub_3", bubble_cnt_o, 32'd3);
`endif

    // Stall while pending, ack two cycles later -> parked then released once
    lat = 2;
    tick();
    chk("st_bubble", {31'h0, if_valid_o}, 32'h0);
    stall_i = 1'b1;
    tick();
    chk("st_req_hold", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("st_addr_hold", imem_bus.imem_addr, 32'h44);
    tick();
    chk("st_parked_req", {31'h0, imem_bus.imem_req}, 32'h0);
    chk("st_hold_pc", if_pc_o, 32'h40);
    chk("st_hold_valid", {31'h0, if_valid_o}, 32'h0);
    tick();
    chk("st_hold_inst", if_inst_o, 32'h893);
    stall_i = 1'b0;
    tick();
    chk("st_rel_valid", {31'h0, if_valid_o}, 32'h1);
    chk("st_rel_pc", if_pc_o, 32'h44);
    chk("st_rel_inst", if_inst_o, 32'h913);
    tick();
    chk("st_no_dup", {31'h0, if_valid_o}, 32'h0);

    // Reset mid-request, then redirect during a 3-cycle-latency fetch
    lat = 3;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("rr_addr", imem_bus.imem_addr, 32'h0);
    tick();
    redir_valid_i = 1'b1;
    redir_pc_i    = 32'h100;
    tick();
    redir_valid_i = 1'b0;
    chk("sq_addr_a", imem_bus.imem_addr, 32'h0);
    chk("sq_req_a", {31'h0, imem_bus.imem_req}, 32'h1);
    tick();
    chk("sq_addr_b", imem_bus.imem_addr, 32'h0);
    tick();
    chk("sq_new_addr", imem_bus.imem_addr, 32'h100);
    chk("sq_discard_v", {31'h0, if_valid_o}, 32'h0);
    chk("sq_discard_pc", if_pc_o, 32'h0);
    lat = 0;
    tick();
    chk("sq_deliv_pc", if_pc_o, 32'h100);
    chk("sq_deliv_inst", if_inst_o, 32'h2093);

    // PC wrap at the top of the address space
    redir_valid_i = 1'b1;
    redir_pc_i    = 32'hFFFF_FFFC;
    tick();
    redir_valid_i = 1'b0;
    chk("wr_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", if_pc_o, 32'hFFFF_FFFC);
    chk("wr_inst", if_inst_o, 32'h13);
    chk("wr_next_addr", imem_bus.imem_addr, 32'h0);
`ifndef FETCH_PERF_CNT_EN
    chk("bub_off", bubble_cnt_o, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
